// File: rtl/pipelined_addsub_if.sv
// Stream interface for pipelined_addsub: operand beat in, result beat out,
// each side with its own valid/ready pair.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into SEG-bit
// segments, one register stage per segment, with a global stall on backpressure.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] bp_q    [STAGES];
  logic [WIDTH-1:0] bp_d    [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic [WIDTH-1:0] s_d     [STAGES];
  logic             c_q     [STAGES];
  logic             c_d     [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             adv;
  logic [WIDTH-1:0] bp_in;
  logic             cin_in;

  // Subtraction is a + ~b + !cin, so stage 0 sees an ordinary add.
  assign bp_in  = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub ? ~bus.cin : bus.cin;

  assign adv           = !(valid_q[LAST] && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  function automatic logic [SEG:0] seg_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             ci,
    input int               k
  );
    return {1'b0, x[k*SEG +: SEG]} + {1'b0, y[k*SEG +: SEG]} + {{SEG{1'b0}}, ci};
  endfunction

  always_comb begin
    logic [SEG:0] seg_sum;
    seg_sum    = seg_add(bus.a, bp_in, cin_in, 0);
    valid_d[0] = bus.in_valid;
    a_d[0]     = bus.a;
    bp_d[0]    = bp_in;
    s_d[0]     = '0;
    s_d[0][SEG-1:0] = seg_sum[SEG-1:0];
    c_d[0]     = seg_sum[SEG];
    for (int k = 1; k < STAGES; k++) begin
      seg_sum    = seg_add(a_q[k-1], bp_q[k-1], c_q[k-1], k);
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      bp_d[k]    = bp_q[k-1];
      s_d[k]     = s_q[k-1];
      s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]     = seg_sum[SEG];
    end
  end

  // Flags are resolved while the top segment is being added.
  always_comb begin
    ovf_d  = (a_d[LAST][MSB] == bp_d[LAST][MSB]) && (s_d[LAST][MSB] != a_d[LAST][MSB]);
    zero_d = (s_d[LAST] == '0);
  end

  // Data registers only load with a valid beat, so bubbles leave the
  // last result visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        bp_q[k]    <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        if (valid_d[k]) begin
          a_q[k]  <= a_d[k];
          bp_q[k] <= bp_d[k];
          s_q[k]  <= s_d[k];
          c_q[k]  <= c_d[k];
        end
      end
      if (valid_d[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: accepted beats push an arithmetic
// reference result; a monitor checks each presented result, its latency and stability.
module tb_pipelined_addsub;
  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;

  logic clk = 1'b0;
  logic rst_n;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    int               acc_cycle;
    int               acc_stalls;
  } exp_t;

  exp_t exp_q[$];
  bit   front_seen  = 1'b0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cycle       = 0;
  int   stall_total = 0;
  int   rdy_mode    = 0;

  // Reference: plain integer arithmetic, signed overflow as range violation.
  function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic cin, input logic sub);
    exp_t r;
    int ua, ub, sa, sb, c, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = int'(cin);
    if (!sub) begin
      ur = ua + ub + c;
      sr = sa + sb + c;
      r.cout = (ur > 65535);
    end else begin
      ur = ua - ub - c;
      sr = sa - sb - c;
      r.cout = (ur >= 0);
    end
    r.sum        = ur[WIDTH-1:0];
    r.ovf        = (sr < -32768) || (sr > 32767);
    r.zero       = (r.sum == '0);
    r.acc_cycle  = 0;
    r.acc_stalls = 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Reset discards everything in flight.
  always @(negedge rst_n) begin
    exp_q.delete();
    front_seen = 1'b0;
  end

  // Monitor: samples mid-cycle the handshake the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!rst_n) begin
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset in_ready", bus.in_ready, 1);
    end else begin
      checkOutput("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          failNow("spurious out_valid with empty scoreboard");
        end else begin
          checkOutput("sum", bus.sum, exp_q[0].sum);
          checkOutput("cout", bus.cout, exp_q[0].cout);
          checkOutput("ovf", bus.ovf, exp_q[0].ovf);
          checkOutput("zero", bus.zero, exp_q[0].zero);
          if (!front_seen) begin
            checkOutput("latency", cycle,
                        exp_q[0].acc_cycle + STAGES + (stall_total - exp_q[0].acc_stalls));
            front_seen = 1'b1;
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e            = refModel(bus.a, bus.b, bus.cin, bus.sub);
        e.acc_cycle  = cycle;
        e.acc_stalls = stall_total;
        exp_q.push_back(e);
      end
      if (bus.out_valid && !bus.out_ready) stall_total++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub);
    bit acc;
    acc          = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) failNow("timeout waiting for in_ready");
  endtask

  task automatic waitDrain();
    rdy_mode = 0;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    checkOutput("drain scoreboard empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    failNow("watchdog expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h0F0F;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    $display("[TB] reset with in_valid held high");
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    $display("[TB] directed corner vectors");
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] random operands with random backpressure");
    rdy_mode = 2;
    repeat (60) applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    waitDrain();

    $display("[TB] back-to-back stream with stall window");
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(16'(i), 16'(i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        rdy_mode = 2;
      end
    join
    waitDrain();

    $display("[TB] reset while stalled mid-stream");
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stalled before reset", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async clear out_valid", bus.out_valid, 0);
    checkOutput("async in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
